// File: rtl/multi_parallel_adc_reader.sv
// Sequencer for N parallel-bus ADCs sharing CONVST, RD and data: one conversion, then one or all reads.
// Define ADC_BUSY_SYNC_EN to pass adc_busy through a 2-flop synchronizer (blanking widens to 3 cycles).
//
// state      | meaning
// IDLE       | waiting for start, bus inactive
// CONVERT    | convst_n low for one cycle
// WAIT_EOC   | blanking, then wait for adc_busy low or timeout
// READ       | cs_n[k] and rd_n low for RD_CYCLES cycles
// RECOVER    | bus released one cycle, sample_valid pulses
module multi_parallel_adc_reader #(
   parameter int N            = 8,
   parameter int DATA_W       = 12,
   parameter int RD_CYCLES    = 2,
   parameter int CONV_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 scan,
   input  logic [$clog2(N)-1:0] adc_index,
   input  logic [DATA_W-1:0]    adc_data,
   input  logic                 adc_busy,
   output logic                 convst_n,
   output logic                 rd_n,
   output logic [N-1:0]         cs_n,
   output logic [DATA_W-1:0]    sample_data,
   output logic [$clog2(N)-1:0] sample_index,
   output logic                 sample_valid,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int IW = $clog2(N);
   localparam int TW = $clog2(CONV_TIMEOUT + 1);
   localparam int RW = $clog2(RD_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONVERT,
      S_WAIT_EOC,
      S_READ,
      S_RECOVER
   } state_t;

   logic eoc_busy;

`ifdef ADC_BUSY_SYNC_EN
   localparam logic [1:0] BLANK = 2'd3;
   logic [1:0] busy_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_sync <= 2'b00;
      else          busy_sync <= {busy_sync[0], adc_busy};
   end
   assign eoc_busy = busy_sync[1];
`else
   localparam logic [1:0] BLANK = 2'd1;
   assign eoc_busy = adc_busy;
`endif

   state_t              state, state_n;
   logic [IW-1:0]       ch, ch_n;
   logic                scan_q, scan_q_n;
   logic [TW-1:0]       tmr, tmr_n;
   logic [1:0]          blank_cnt, blank_cnt_n;
   logic [RW-1:0]       rd_cnt, rd_cnt_n;
   logic                convst_n_n, rd_n_n, sample_valid_n, busy_n, timeout_err_n;
   logic [N-1:0]        cs_n_n;
   logic [DATA_W-1:0]   sample_data_n;
   logic [IW-1:0]       sample_index_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         ch           <= '0;
         scan_q       <= 1'b0;
         tmr          <= '0;
         blank_cnt    <= 2'd0;
         rd_cnt       <= '0;
         convst_n     <= 1'b1;
         rd_n         <= 1'b1;
         cs_n         <= '1;
         sample_data  <= '0;
         sample_index <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_n;
         ch           <= ch_n;
         scan_q       <= scan_q_n;
         tmr          <= tmr_n;
         blank_cnt    <= blank_cnt_n;
         rd_cnt       <= rd_cnt_n;
         convst_n     <= convst_n_n;
         rd_n         <= rd_n_n;
         cs_n         <= cs_n_n;
         sample_data  <= sample_data_n;
         sample_index <= sample_index_n;
         sample_valid <= sample_valid_n;
         busy         <= busy_n;
         timeout_err  <= timeout_err_n;
      end
   end

   always_comb begin
      state_n        = state;
      ch_n           = ch;
      scan_q_n       = scan_q;
      tmr_n          = tmr;
      blank_cnt_n    = blank_cnt;
      rd_cnt_n       = rd_cnt;
      sample_data_n  = sample_data;
      sample_index_n = sample_index;
      sample_valid_n = 1'b0;
      busy_n         = busy;
      timeout_err_n  = timeout_err;

      case (state)
         S_IDLE: begin
            if (start) begin
               scan_q_n      = scan;
               ch_n          = scan ? '0 : adc_index;
               busy_n        = 1'b1;
               timeout_err_n = 1'b0;
               state_n       = S_CONVERT;
            end
         end
         S_CONVERT: begin
            tmr_n       = TW'(CONV_TIMEOUT);
            blank_cnt_n = BLANK;
            state_n     = S_WAIT_EOC;
         end
         S_WAIT_EOC: begin
            // The timer keeps running through blanking so its budget counts from convst.
            if (blank_cnt != 2'd0) begin
               blank_cnt_n = blank_cnt - 2'd1;
               if (tmr > TW'(1)) tmr_n = tmr - 1'b1;
            end else if (!eoc_busy) begin
               rd_cnt_n = RW'(RD_CYCLES - 1);
               state_n  = S_READ;
            end else if (tmr <= TW'(1)) begin
               timeout_err_n = 1'b1;
               busy_n        = 1'b0;
               state_n       = S_IDLE;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         S_READ: begin
            if (rd_cnt == '0) begin
               sample_data_n  = adc_data;
               sample_index_n = ch;
               sample_valid_n = 1'b1;
               state_n        = S_RECOVER;
            end else begin
               rd_cnt_n = rd_cnt - 1'b1;
            end
         end
         S_RECOVER: begin
            if (scan_q && (ch != IW'(N - 1))) begin
               ch_n     = ch + 1'b1;
               rd_cnt_n = RW'(RD_CYCLES - 1);
               state_n  = S_READ;
            end else begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Bus strobes follow the next state so they are registered yet aligned with it.
      convst_n_n = (state_n != S_CONVERT);
      rd_n_n     = (state_n != S_READ);
      cs_n_n     = '1;
      if (state_n == S_READ) cs_n_n[ch_n] = 1'b0;
   end

endmodule
